// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: frame sequencer for the 2x2 pixel array.
// Steps ERASE -> EXPOSE -> CONVERT -> READ0 -> READ1 and drives registered array control lines.
module pixel_frame_ctrl #(
    parameter int C_ERASE   = 5,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5,
    parameter int EXP_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             CONTINUOUS,
    input  logic             ABORT,
    input  logic [EXP_W-1:0] EXP_TIME,
    output logic             ARRAY_RESET,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             CONVERT,
    output logic             RAMP,
    output logic             READ0,
    output logic             READ1,
    output logic             ROW_VALID,
    output logic             ROW_SEL,
    output logic             BUSY,
    output logic             FRAME_DONE,
    output logic [7:0]       FRAME_CNT
);

    localparam int MAX_A = (C_ERASE > C_CONVERT) ? C_ERASE : C_CONVERT;
    localparam int MAX_B = (MAX_A > C_READ) ? MAX_A : C_READ;
    localparam int MAX_D = (MAX_B > (1 << EXP_W)) ? MAX_B : (1 << EXP_W);
    localparam int CNT_W = $clog2(MAX_D);

    localparam logic [CNT_W-1:0] ERASE_LD   = CNT_W'(C_ERASE - 1);
    localparam logic [CNT_W-1:0] CONVERT_LD = CNT_W'(C_CONVERT - 1);
    localparam logic [CNT_W-1:0] READ_LD    = CNT_W'(C_READ - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ0   = 3'd4;
    localparam logic [2:0] S_READ1   = 3'd5;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [EXP_W-1:0] exp_lat, exp_nx;
    logic [CNT_W-1:0] expose_ld;
    logic             frame_end;

    // A zero exposure still spends one cycle in EXPOSE.
    assign expose_ld = (exp_lat == '0) ? '0 : CNT_W'(exp_lat - EXP_W'(1));

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        exp_nx    = exp_lat;
        frame_end = 1'b0;
        if (ABORT) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (state == S_IDLE) begin
            if (START) begin
                state_nx = S_ERASE;
                cnt_nx   = ERASE_LD;
                exp_nx   = EXP_TIME;
            end
        end else if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
        end else begin
            case (state)
                S_ERASE:   begin state_nx = S_EXPOSE;  cnt_nx = expose_ld;  end
                S_EXPOSE:  begin state_nx = S_CONVERT; cnt_nx = CONVERT_LD; end
                S_CONVERT: begin state_nx = S_READ0;   cnt_nx = READ_LD;    end
                S_READ0:   begin state_nx = S_READ1;   cnt_nx = READ_LD;    end
                S_READ1: begin
                    frame_end = 1'b1;
                    if (CONTINUOUS) begin
                        state_nx = S_ERASE;
                        cnt_nx   = ERASE_LD;
                        exp_nx   = EXP_TIME;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                default:   begin state_nx = S_IDLE;    cnt_nx = '0;         end
            endcase
        end
    end

    // Outputs are decoded from the next state so the flops line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            exp_lat     <= EXP_W'(1);
            ARRAY_RESET <= 1'b1;
            ERASE       <= 1'b0;
            EXPOSE      <= 1'b0;
            CONVERT     <= 1'b0;
            RAMP        <= 1'b0;
            READ0       <= 1'b0;
            READ1       <= 1'b0;
            ROW_VALID   <= 1'b0;
            ROW_SEL     <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_CNT   <= 8'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            exp_lat     <= exp_nx;
            ARRAY_RESET <= (state_nx == S_ERASE);
            ERASE       <= (state_nx == S_ERASE);
            EXPOSE      <= (state_nx == S_EXPOSE);
            CONVERT     <= (state_nx == S_CONVERT);
            RAMP        <= (state_nx == S_CONVERT) && (cnt_nx != CONVERT_LD);
            READ0       <= (state_nx == S_READ0);
            READ1       <= (state_nx == S_READ1);
            ROW_VALID   <= ((state_nx == S_READ0) || (state_nx == S_READ1)) && (cnt_nx == '0);
            FRAME_DONE  <= (state_nx == S_READ1) && (cnt_nx == '0);
            BUSY        <= (state_nx != S_IDLE);
            if (((state_nx == S_READ0) || (state_nx == S_READ1)) && (cnt_nx == '0))
                ROW_SEL <= (state_nx == S_READ1);
            if (frame_end)
                FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: directed scenarios plus random stimulus against a per-cycle timeline model.
// The model expands each frame into a queue of expected cycles and is compared every cycle.
module tb_pixel_frame_ctrl;

    localparam int C_ERASE   = 5;
    localparam int C_CONVERT = 255;
    localparam int C_READ    = 5;
    localparam int EXP_W     = 8;

    logic             CLK = 1'b0;
    logic             RESET_N, START, CONTINUOUS, ABORT;
    logic [EXP_W-1:0] EXP_TIME;
    logic             ARRAY_RESET, ERASE, EXPOSE, CONVERT, RAMP, READ0, READ1;
    logic             ROW_VALID, ROW_SEL, BUSY, FRAME_DONE;
    logic [7:0]       FRAME_CNT;

    always #5 CLK = ~CLK;

    pixel_frame_ctrl #(
        .C_ERASE(C_ERASE), .C_CONVERT(C_CONVERT), .C_READ(C_READ), .EXP_W(EXP_W)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CONTINUOUS(CONTINUOUS),
        .ABORT(ABORT), .EXP_TIME(EXP_TIME), .ARRAY_RESET(ARRAY_RESET), .ERASE(ERASE),
        .EXPOSE(EXPOSE), .CONVERT(CONVERT), .RAMP(RAMP), .READ0(READ0), .READ1(READ1),
        .ROW_VALID(ROW_VALID), .ROW_SEL(ROW_SEL), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
        .FRAME_CNT(FRAME_CNT)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Bit order: array_reset erase expose convert ramp read0 read1 row_valid row_sel busy frame_done
    logic [10:0] dut_vec;
    assign dut_vec = {ARRAY_RESET, ERASE, EXPOSE, CONVERT, RAMP, READ0, READ1,
                      ROW_VALID, ROW_SEL, BUSY, FRAME_DONE};

    // Phase codes: 1 erase, 2 expose, 3 convert, 4 read0, 5 read1.
    typedef struct {
        int ph;
        bit ramp;
        bit rv;
        bit last;
    } step_t;

    step_t       q[$];
    logic [10:0] exp_vec = '0;
    logic [7:0]  exp_cnt = '0;
    bit          m_row_sel = 1'b0;
    int          m_frames = 0;

    task automatic push_frame(input int e);
        int d;
        d = (e == 0) ? 1 : e;
        for (int i = 0; i < C_ERASE; i++)   q.push_back('{ph: 1, ramp: 1'b0, rv: 1'b0, last: 1'b0});
        for (int i = 0; i < d; i++)         q.push_back('{ph: 2, ramp: 1'b0, rv: 1'b0, last: 1'b0});
        for (int i = 0; i < C_CONVERT; i++) q.push_back('{ph: 3, ramp: (i != 0), rv: 1'b0, last: 1'b0});
        for (int i = 0; i < C_READ; i++)    q.push_back('{ph: 4, ramp: 1'b0, rv: (i == C_READ - 1), last: 1'b0});
        for (int i = 0; i < C_READ; i++)
            q.push_back('{ph: 5, ramp: 1'b0, rv: (i == C_READ - 1), last: (i == C_READ - 1)});
    endtask

    // Reference model: the queue front is the cycle that follows the current edge.
    initial begin
        step_t s;
        forever begin
            @(posedge CLK);
            if (!RESET_N) begin
                q.delete();
                m_frames  = 0;
                m_row_sel = 1'b0;
                exp_vec   = 11'b100_0000_0000;
            end else begin
                if (ABORT) begin
                    q.delete();
                end else if (q.size() == 0) begin
                    if (START) push_frame(int'(EXP_TIME));
                end else begin
                    s = q.pop_front();
                    if (s.last) begin
                        m_frames = (m_frames + 1) % 256;
                        if (CONTINUOUS) push_frame(int'(EXP_TIME));
                    end
                end
                exp_vec = '0;
                if (q.size() != 0) begin
                    s = q[0];
                    if (s.rv) m_row_sel = (s.ph == 5);
                    exp_vec[10] = (s.ph == 1);
                    exp_vec[9]  = (s.ph == 1);
                    exp_vec[8]  = (s.ph == 2);
                    exp_vec[7]  = (s.ph == 3);
                    exp_vec[6]  = s.ramp;
                    exp_vec[5]  = (s.ph == 4);
                    exp_vec[4]  = (s.ph == 5);
                    exp_vec[3]  = s.rv;
                    exp_vec[1]  = 1'b1;
                    exp_vec[0]  = s.last;
                end
                exp_vec[2] = m_row_sel;
            end
            exp_cnt = 8'(m_frames);
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            check("outputs", 32'(dut_vec), 32'(exp_vec));
            check("frame_cnt", 32'(FRAME_CNT), 32'(exp_cnt));
        end
    end

    // Starts a single frame and watches it until BUSY drops; n counts cycles after the START edge.
    task automatic run_frame(input logic [EXP_W-1:0] e, output int n_ramp, output int n_expose,
                             output int rv0_at, output int rv1_at, output int n_done);
        int n;
        n = 0; n_ramp = 0; n_expose = 0; rv0_at = 0; rv1_at = 0; n_done = 0;
        EXP_TIME = e;
        START = 1'b1;
        do begin
            @(negedge CLK);
            START = 1'b0;
            n++;
            if (RAMP) n_ramp++;
            if (EXPOSE) n_expose++;
            if (ROW_VALID && !ROW_SEL && rv0_at == 0) rv0_at = n;
            if (ROW_VALID && ROW_SEL && rv1_at == 0) rv1_at = n;
            if (FRAME_DONE) n_done++;
        end while (BUSY && n < 2000);
        check("frame_timeout", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_until_phase(input string name, input int which);
        int k;
        logic hit;
        k = 0;
        hit = 1'b0;
        while (!hit && k < 1000) begin
            @(negedge CLK);
            k++;
            hit = (which == 2) ? EXPOSE : (which == 3) ? CONVERT : READ0;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    initial begin
        int n_ramp, n_expose, rv0_at, rv1_at, n_done, done, k, cnt_before;
        int exp_len[3];

        RESET_N = 1'b0; START = 1'b0; CONTINUOUS = 1'b0; ABORT = 1'b0; EXP_TIME = '0;
        repeat (2) @(negedge CLK);
        check("reset_array_reset", 32'(ARRAY_RESET), 32'd1);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_frame_cnt", 32'(FRAME_CNT), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single frame, EXP_TIME = 10.
        run_frame(8'd10, n_ramp, n_expose, rv0_at, rv1_at, n_done);
        check("f1_expose_len", 32'(n_expose), 32'd10);
        check("f1_rv0_cycle", 32'(rv0_at), 32'd275);
        check("f1_rv1_cycle", 32'(rv1_at), 32'd280);
        check("f1_done_count", 32'(n_done), 32'd1);
        check("f1_frame_cnt", 32'(FRAME_CNT), 32'd1);

        // Zero exposure still takes one cycle; conversion gives C_CONVERT-1 ramp pulses.
        run_frame(8'd0, n_ramp, n_expose, rv0_at, rv1_at, n_done);
        check("f2_expose_len", 32'(n_expose), 32'd1);
        check("f2_ramp_edges", 32'(n_ramp), 32'd254);
        check("f2_frame_cnt", 32'(FRAME_CNT), 32'd2);

        // Continuous mode: EXP_TIME changes mid-frame apply from the next frame on.
        exp_len = '{0, 0, 0};
        done = 0; k = 0;
        CONTINUOUS = 1'b1; EXP_TIME = 8'd10; START = 1'b1;
        do begin
            @(negedge CLK);
            START = 1'b0;
            k++;
            if (CONVERT && done == 0) EXP_TIME = 8'd3;
            if (CONVERT && done == 1) EXP_TIME = 8'd7;
            if (done == 2) CONTINUOUS = 1'b0;
            if (EXPOSE && done < 3) exp_len[done]++;
            if (FRAME_DONE) done++;
        end while (BUSY && k < 3000);
        check("cont_timeout", 32'(BUSY), 32'd0);
        check("cont_frames", 32'(done), 32'd3);
        check("cont_exp0", 32'(exp_len[0]), 32'd10);
        check("cont_exp1", 32'(exp_len[1]), 32'd3);
        check("cont_exp2", 32'(exp_len[2]), 32'd7);
        check("cont_frame_cnt", 32'(FRAME_CNT), 32'd5);

        // Abort in CONVERT cycle 100.
        cnt_before = int'(FRAME_CNT);
        EXP_TIME = 8'd4; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_until_phase("reach_convert", 3);
        repeat (99) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_lines", 32'(dut_vec & 11'b111_1111_1011), 32'd0);
        check("abort_frame_cnt", 32'(FRAME_CNT), 32'(cnt_before));
        START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("start_abort_idle", 32'(BUSY), 32'd0);
        @(negedge CLK);

        // START during EXPOSE is ignored, then reset in READ0.
        EXP_TIME = 8'd6; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_until_phase("reach_expose", 2);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_until_phase("reach_read0", 4);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check("mid_reset_busy", 32'(BUSY), 32'd0);
        check("mid_reset_frame_cnt", 32'(FRAME_CNT), 32'd0);
        check("mid_reset_array_reset", 32'(ARRAY_RESET), 32'd1);
        @(negedge CLK);

        // 256 back-to-back frames wrap the counter to 0.
        done = 0; k = 0;
        CONTINUOUS = 1'b1; EXP_TIME = 8'd0; START = 1'b1;
        do begin
            @(negedge CLK);
            START = 1'b0;
            k++;
            if (done == 255) CONTINUOUS = 1'b0;
            if (FRAME_DONE) done++;
        end while (BUSY && k < 75000);
        check("wrap_timeout", 32'(BUSY), 32'd0);
        check("wrap_frames", 32'(done), 32'd256);
        check("wrap_frame_cnt", 32'(FRAME_CNT), 32'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLK);
            START    = ($urandom % 40) == 0;
            ABORT    = ($urandom % 700) == 0;
            RESET_N  = ($urandom % 3000) != 0;
            EXP_TIME = 8'($urandom_range(0, 20));
            if (($urandom % 500) == 0) CONTINUOUS = ~CONTINUOUS;
        end
        RESET_N = 1'b1; START = 1'b0; ABORT = 1'b0; CONTINUOUS = 1'b0;
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
